// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for mem_port_arbiter: FSM states, grant source and the latched memory request.
// Request field widths are fixed here, so the arbiter's LINE_W/ADDR_W must match them.
package mem_port_arbiter_pkg;

  localparam int ARB_LINE_W     = 256;
  localparam int ARB_ADDR_W     = 32;
  localparam int ARB_STARVE_MAX = 8;

  typedef enum logic [1:0] {
    IDLE,
    SERVE_I,
    SERVE_D
  } arb_state_t;

  typedef enum logic {
    SRC_I,
    SRC_D
  } arb_src_t;

  typedef struct packed {
    logic                  read;
    logic                  write;
    logic [ARB_ADDR_W-1:0] addr;
    logic [ARB_LINE_W-1:0] wdata;
  } mem_req_t;

  // Round-robin tie break: whoever was not granted last time goes next.
  function automatic arb_src_t rr_pick(input arb_src_t last);
    return (last == SRC_D) ? SRC_I : SRC_D;
  endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares the cacheline memory port between the I-cache and D-cache miss paths, one transaction at a time.
// Default: fixed D priority with an I starvation guard; define ARB_ROUND_ROBIN_EN for round-robin grants.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int LINE_W     = ARB_LINE_W,
  parameter int ADDR_W     = ARB_ADDR_W,
  parameter int STARVE_MAX = ARB_STARVE_MAX
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp
);

  arb_state_t state, state_next;
  mem_req_t   req_q, req_next;
  arb_src_t   last_grant;
  logic       i_req, d_req;
  logic       grant_i, grant_d;

  assign i_req = i_read;
  assign d_req = d_read | d_write;

`ifndef ARB_ROUND_ROBIN_EN
  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  logic [CNT_W-1:0] starve_cnt;
  logic             starve_hit;

  assign starve_hit = (starve_cnt == CNT_W'(STARVE_MAX));
`endif

  // Grant decision is only meaningful in IDLE; requests arriving mid-transaction just wait.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (state == IDLE) begin
`ifdef ARB_ROUND_ROBIN_EN
      if (d_req && i_req) begin
        grant_i = (rr_pick(last_grant) == SRC_I);
        grant_d = (rr_pick(last_grant) == SRC_D);
      end else begin
        grant_i = i_req;
        grant_d = d_req;
      end
`else
      if (d_req && !(i_req && starve_hit)) begin
        grant_d = 1'b1;
      end else if (i_req) begin
        grant_i = 1'b1;
      end
`endif
    end
  end

  // Next state, next latched request and response routing.
  always_comb begin
    state_next = state;
    req_next   = req_q;
    i_resp     = 1'b0;
    d_resp     = 1'b0;
    unique case (state)
      IDLE: begin
        if (grant_d) begin
          state_next = SERVE_D;
          req_next   = '{read: d_read, write: d_write, addr: d_addr, wdata: d_wdata};
        end else if (grant_i) begin
          state_next = SERVE_I;
          req_next   = '{read: 1'b1, write: 1'b0, addr: i_addr, wdata: '0};
        end
      end
      SERVE_I, SERVE_D: begin
        i_resp = (state == SERVE_I) && mem_resp;
        d_resp = (state == SERVE_D) && mem_resp;
        if (mem_resp) begin
          // Dropping the strobes guarantees an idle cycle before the next grant.
          state_next     = IDLE;
          req_next.read  = 1'b0;
          req_next.write = 1'b0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      state      <= IDLE;
      req_q      <= '0;
      last_grant <= SRC_D;
    end else begin
      state <= state_next;
      req_q <= req_next;
      if (grant_d) begin
        last_grant <= SRC_D;
      end else if (grant_i) begin
        last_grant <= SRC_I;
      end
    end
  end

`ifndef ARB_ROUND_ROBIN_EN
  // Counts D wins that left I waiting; cleared whenever I is served or nobody was waiting.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (grant_i) begin
      starve_cnt <= '0;
    end else if (grant_d) begin
      if (!i_req) begin
        starve_cnt <= '0;
      end else if (!starve_hit) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end
`endif

  assign mem_read  = req_q.read;
  assign mem_write = req_q.write;
  assign mem_addr  = req_q.addr;
  assign mem_wdata = req_q.wdata;

  // Data always passes through; only the matching resp qualifies it.
  assign i_rdata = mem_rdata;
  assign d_rdata = mem_rdata;

  a_d_op_exclusive : assert property (@(posedge clk) disable iff (rst) !(d_read && d_write));
  a_mem_op_exclusive : assert property (@(posedge clk) !(mem_read && mem_write));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table plus hand-written multi-cycle sequences.
// Expected transactions are queued in grant order and checked as the memory port presents them.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int LW = ARB_LINE_W;
  localparam int AW = ARB_ADDR_W;
  localparam int SM = ARB_STARVE_MAX;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_read;
  logic [AW-1:0] i_addr;
  logic [LW-1:0] i_rdata;
  logic          i_resp;
  logic          d_read;
  logic          d_write;
  logic [AW-1:0] d_addr;
  logic [LW-1:0] d_wdata;
  logic [LW-1:0] d_rdata;
  logic          d_resp;
  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_addr;
  logic [LW-1:0] mem_wdata;
  logic [LW-1:0] mem_rdata;
  logic          mem_resp;

  mem_port_arbiter #(.LINE_W(LW), .ADDR_W(AW), .STARVE_MAX(SM)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  always #5 clk = ~clk;

  typedef struct {
    arb_src_t      src;
    logic          read;
    logic          write;
    logic [AW-1:0] addr;
    logic [LW-1:0] wdata;
  } exp_t;

  typedef struct {
    logic          i_read;
    logic          d_read;
    logic          d_write;
    logic [AW-1:0] addr;
    logic [LW-1:0] wdata;
    logic [LW-1:0] rdata;
    int            delay;
  } vec_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input arb_src_t src, input logic rd, input logic wr,
                          input logic [AW-1:0] addr, input logic [LW-1:0] wdata);
    exp_t e;
    e.src = src; e.read = rd; e.write = wr; e.addr = addr; e.wdata = wdata;
    sb.push_back(e);
  endtask

  task automatic wait_grant(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (mem_read || mem_write) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL grant_timeout: got no mem_read/mem_write want a grant within 100 cycles");
    end
  endtask

  // Serves one granted transaction: checks the request, holds it for `delay` cycles,
  // answers with rdata, checks the routed response and the idle gap that follows.
  task automatic expect_txn(input int delay, input bit drop, input logic [LW-1:0] rdata,
                            input bit raise_i, input logic [AW-1:0] raise_addr);
    bit   ok;
    bit   stable;
    exp_t e;
    wait_grant(ok);
    if (!ok) return;
    n_cmp++;
    if (sb.size() == 0) begin
      n_bad++;
      $display("FAIL scoreboard_empty: got a grant to %0h want none", mem_addr);
      return;
    end
    e = sb.pop_front();
    check("mem_read", mem_read, e.read);
    check("mem_write", mem_write, e.write);
    check("mem_addr", mem_addr, e.addr);
    if (e.write) check("mem_wdata", mem_wdata, e.wdata);
    if (raise_i) begin
      i_read = 1'b1;
      i_addr = raise_addr;
      push_exp(SRC_I, 1'b1, 1'b0, raise_addr, '0);
    end
    stable = 1'b1;
    repeat (delay) begin
      @(negedge clk);
      if (mem_read !== e.read || mem_write !== e.write || mem_addr !== e.addr || i_resp || d_resp)
        stable = 1'b0;
    end
    check("hold_stable", stable, 1'b1);
    mem_rdata = rdata;
    mem_resp  = 1'b1;
    #1;
    check("i_resp", i_resp, e.src == SRC_I);
    check("d_resp", d_resp, e.src == SRC_D);
    if (e.src == SRC_I) check("i_rdata", i_rdata, rdata);
    else                check("d_rdata", d_rdata, rdata);
    @(posedge clk);
    #1;
    mem_resp = 1'b0;
    if (drop) begin
      if (e.src == SRC_I) i_read = 1'b0;
      else begin
        d_read  = 1'b0;
        d_write = 1'b0;
      end
    end
    @(negedge clk);
    check("idle_gap", {mem_read, mem_write}, 2'b00);
  endtask

  vec_t vecs[4];

  initial begin
    bit ok;
    exp_t e;
    rst = 1'b1; i_read = 1'b0; i_addr = '0; d_read = 1'b0; d_write = 1'b0;
    d_addr = '0; d_wdata = '0; mem_rdata = '0; mem_resp = 1'b0;

    vecs[0] = '{i_read: 1'b1, d_read: 1'b0, d_write: 1'b0, addr: 32'h0000_0060,
                wdata: '0, rdata: {32{8'hAA}}, delay: 0};
    vecs[1] = '{i_read: 1'b0, d_read: 1'b1, d_write: 1'b0, addr: 32'h0000_1000,
                wdata: '0, rdata: {8{32'hDEAD_BEEF}}, delay: 1};
    vecs[2] = '{i_read: 1'b0, d_read: 1'b0, d_write: 1'b1, addr: 32'h0000_2040,
                wdata: {8{32'h1234_5678}}, rdata: '0, delay: 3};
    vecs[3] = '{i_read: 1'b1, d_read: 1'b0, d_write: 1'b0, addr: 32'hFFFF_FFE0,
                wdata: '0, rdata: {LW{1'b1}}, delay: 0};

    repeat (3) @(negedge clk);
    check("rst_mem_read", mem_read, 1'b0);
    check("rst_mem_write", mem_write, 1'b0);
    check("rst_i_resp", i_resp, 1'b0);
    check("rst_d_resp", d_resp, 1'b0);
    check("rst_mem_addr", mem_addr, '0);
    check("rst_mem_wdata", mem_wdata, '0);
    rst = 1'b0;

    // Sole requesters: behaviour identical in both arbitration modes.
    for (int v = 0; v < 4; v++) begin
      i_read  = vecs[v].i_read;
      d_read  = vecs[v].d_read;
      d_write = vecs[v].d_write;
      if (vecs[v].i_read) begin
        i_addr = vecs[v].addr;
        push_exp(SRC_I, 1'b1, 1'b0, vecs[v].addr, '0);
      end else begin
        d_addr  = vecs[v].addr;
        d_wdata = vecs[v].wdata;
        push_exp(SRC_D, vecs[v].d_read, vecs[v].d_write, vecs[v].addr, vecs[v].wdata);
      end
      expect_txn(vecs[v].delay, 1'b1, vecs[v].rdata, 1'b0, '0);
    end

`ifndef ARB_ROUND_ROBIN_EN
    // Simultaneous D write and I read: D first, I after one idle cycle.
    d_write = 1'b1; d_addr = 32'h0000_0A00; d_wdata = {16{16'hC0DE}};
    i_read  = 1'b1; i_addr = 32'h0000_0B00;
    push_exp(SRC_D, 1'b0, 1'b1, 32'h0000_0A00, {16{16'hC0DE}});
    push_exp(SRC_I, 1'b1, 1'b0, 32'h0000_0B00, '0);
    expect_txn(0, 1'b1, {8{32'h0D0D_0D0D}}, 1'b0, '0);
    expect_txn(0, 1'b1, {8{32'h1111_2222}}, 1'b0, '0);

    // Both held: STARVE_MAX D transactions, then I is forced, then D resumes.
    d_read = 1'b1; d_addr = 32'h0000_3000;
    i_read = 1'b1; i_addr = 32'h0000_4000;
    for (int k = 0; k < SM; k++) push_exp(SRC_D, 1'b1, 1'b0, 32'h0000_3000, '0);
    push_exp(SRC_I, 1'b1, 1'b0, 32'h0000_4000, '0);
    push_exp(SRC_D, 1'b1, 1'b0, 32'h0000_3000, '0);
    for (int k = 0; k < SM; k++) expect_txn(0, 1'b0, LW'(k), 1'b0, '0);
    expect_txn(0, 1'b1, {4{64'h5151_5151_5151_5151}}, 1'b0, '0);
    check("starve_cnt_cleared", dut.starve_cnt, '0);
    expect_txn(0, 1'b1, {4{64'h7777_0000_7777_0000}}, 1'b0, '0);
`endif

    // Slow adaptor: D held for 20 cycles while a new I request arrives and waits.
    d_read = 1'b1; d_addr = 32'h0000_5000;
    push_exp(SRC_D, 1'b1, 1'b0, 32'h0000_5000, '0);
    expect_txn(20, 1'b1, {8{32'h5555_AAAA}}, 1'b1, 32'h0000_6000);
    expect_txn(0, 1'b1, {8{32'h6666_9999}}, 1'b0, '0);

    // Reset in the middle of a D transaction; the still-pending request is re-granted.
    d_read = 1'b1; d_addr = 32'h0000_7000;
    push_exp(SRC_D, 1'b1, 1'b0, 32'h0000_7000, '0);
    wait_grant(ok);
    if (ok) begin
      e = sb.pop_front();
      check("pre_rst_addr", mem_addr, e.addr);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_mem_read", mem_read, 1'b0);
    check("mid_rst_d_resp", d_resp, 1'b0);
    check("mid_rst_state", dut.state, IDLE);
    @(negedge clk);
    rst = 1'b0;
    push_exp(SRC_D, 1'b1, 1'b0, 32'h0000_7000, '0);
    expect_txn(0, 1'b1, {8{32'h7070_7070}}, 1'b0, '0);

`ifdef ARB_ROUND_ROBIN_EN
    // Fresh reset leaves last_grant=D, so continuous contention alternates starting with I.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    i_read = 1'b1; i_addr = 32'h0000_8000;
    d_read = 1'b1; d_addr = 32'h0000_9000;
    for (int k = 0; k < 2; k++) begin
      push_exp(SRC_I, 1'b1, 1'b0, 32'h0000_8000, '0);
      push_exp(SRC_D, 1'b1, 1'b0, 32'h0000_9000, '0);
    end
    push_exp(SRC_I, 1'b1, 1'b0, 32'h0000_8000, '0);
    for (int k = 0; k < 4; k++) expect_txn(0, k == 3, LW'(k + 100), 1'b0, '0);
    expect_txn(0, 1'b1, LW'(200), 1'b0, '0);
`endif

    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_leftover: got %0d entries want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion want finish before 200000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
